pipeline_hazard_ctrl: RTL

Central stall/flush controller for the RV32IM five-stage pipeline. Each cycle it generates per-register enable and flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable. Sources are instruction/data memory busywait, load-use hazards, taken branches/jumps resolved in EX, and multi-cycle M-extension operations. It sits beside the pipeline registers and replaces the single shared BUSYWAIT hold with per-stage control.

---
 rtl/pipeline_ctrl_pkg.sv | 37 +++
 rtl/muldiv_stall_counter.sv | 97 +++++++++
 rtl/pipeline_hazard_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: mul/div FSM
// state encoding, EX_MULDIV_OP encodings and the architectural zero register.
package pipeline_ctrl_pkg;

  // Controller state: RUN = 0, MD_WAIT = 1
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_e;

  // EX_MULDIV_OP encodings; MD_RSVD behaves exactly like MD_NONE
  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_op_e;

  // x0 is hard-wired to zero, so a load into it never creates a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Width of the mul/div down-counter
  localparam int unsigned MD_CNT_W = 6;

  // True only for the two real op classes; reserved and unknown codes are no-ops
  function automatic logic md_op_valid(input logic [1:0] op);
    logic v;
    v = 1'b0;
    case (op)
      MD_MUL:  v = 1'b1;
      MD_DIV:  v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/muldiv_stall_counter.sv
// Mul/div occupancy tracker. Owns the RUN/MD_WAIT state, the down-counter
// and the MULDIV_START pulse. Outputs are raw (not gated by reset); the top
// level applies reset forcing and priority.
module muldiv_stall_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 34
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       freeze_i,
  input  logic [1:0] op_i,
  output logic       stall_o,
  output logic       start_o,
  output logic       busy_o
);

  // Counter preload is L - 2: the first EX cycle is spent in RUN and the
  // release cycle is spent in MD_WAIT with the counter already at zero.
  localparam logic [MD_CNT_W-1:0] MUL_LOAD =
    (MUL_LATENCY > 1) ? MD_CNT_W'(MUL_LATENCY - 2) : '0;
  localparam logic [MD_CNT_W-1:0] DIV_LOAD =
    (DIV_LATENCY > 1) ? MD_CNT_W'(DIV_LATENCY - 2) : '0;
  localparam logic MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic DIV_MULTI = (DIV_LATENCY > 1);

  md_state_e             state_q;
  logic [MD_CNT_W-1:0]   cnt_q;
  logic                  op_valid;
  logic                  lat_multi;
  logic [MD_CNT_W-1:0]   load_val;
  logic                  cnt_zero;
  logic                  in_run;
  logic                  in_wait;

  // Decode the op in EX into "multi-cycle?" and the counter preload
  always_comb begin
    op_valid  = md_op_valid(op_i);
    lat_multi = 1'b0;
    load_val  = '0;
    case (op_i)
      MD_MUL: begin
        lat_multi = MUL_MULTI;
        load_val  = MUL_LOAD;
      end
      MD_DIV: begin
        lat_multi = DIV_MULTI;
        load_val  = DIV_LOAD;
      end
      default: begin
        lat_multi = 1'b0;
        load_val  = '0;
      end
    endcase
  end

  assign cnt_zero = (cnt_q == '0);
  assign in_run   = (state_q == ST_RUN);
  assign in_wait  = (state_q == ST_MD_WAIT);

  // Stall on the first EX cycle of a multi-cycle op and while the counter runs
  assign stall_o = (in_run && op_valid && lat_multi) || (in_wait && !cnt_zero);
  // Start is deferred through freeze cycles; single-cycle ops also pulse it
  assign start_o = in_run && op_valid && !freeze_i;
  assign busy_o  = in_wait;

  // FSM: enter MD_WAIT on an unfrozen multi-cycle op, count down regardless
  // of freeze, and leave only on an unfrozen cycle with the counter at zero
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (op_valid && lat_multi && !freeze_i) begin
            state_q <= ST_MD_WAIT;
            cnt_q   <= load_val;
          end
        end
        ST_MD_WAIT: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - MD_CNT_W'(1);
          end else if (!freeze_i) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage RV32IM pipeline.
// Produces per-register enable/flush controls and the PC enable from memory
// busywait, load-use hazards, taken branches and multi-cycle mul/div ops.
// Optional feature: define PIPE_PERF_CNT_EN to add STALL_COUNT/FLUSH_COUNT.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 34
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IMEM_BUSYWAIT,
  input  logic        DMEM_BUSYWAIT,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_RD,
  input  logic        EX_IS_LOAD,
  input  logic        EX_BRANCH_TAKEN,
  input  logic [1:0]  EX_MULDIV_OP,
  output logic        PC_EN,
  output logic        IF_ID_EN,
  output logic        ID_EX_EN,
  output logic        EX_MEM_EN,
  output logic        MEM_WB_EN,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_FLUSH,
  output logic        EX_MEM_FLUSH,
  output logic        MULDIV_START,
  output logic        MULDIV_BUSY
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] STALL_COUNT,
  output logic [31:0] FLUSH_COUNT
`endif
);

  logic freeze;
  logic md_stall;
  logic md_start;
  logic md_busy;
  logic load_use;

  assign freeze = IMEM_BUSYWAIT || DMEM_BUSYWAIT;

  muldiv_stall_counter #(
    .MUL_LATENCY (MUL_LATENCY),
    .DIV_LATENCY (DIV_LATENCY)
  ) u_md_cnt (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .freeze_i (freeze),
    .op_i     (EX_MULDIV_OP),
    .stall_o  (md_stall),
    .start_o  (md_start),
    .busy_o   (md_busy)
  );

  assign load_use = EX_IS_LOAD && (EX_RD != REG_ZERO) &&
                    ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  assign MULDIV_START = RESET && md_start;
  assign MULDIV_BUSY  = RESET && md_busy;

  // Priority resolution: reset, freeze, mul/div, branch, load-use, normal
  always_comb begin
    PC_EN        = 1'b0;
    IF_ID_EN     = 1'b0;
    ID_EX_EN     = 1'b0;
    EX_MEM_EN    = 1'b0;
    MEM_WB_EN    = 1'b0;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    EX_MEM_FLUSH = 1'b0;
    if (!RESET || freeze) begin
      // Whole pipeline holds; nothing captures, nothing is flushed
    end else if (md_stall) begin
      // Op stays in EX; a bubble flows on into MEM behind it
      EX_MEM_EN    = 1'b1;
      EX_MEM_FLUSH = 1'b1;
      MEM_WB_EN    = 1'b1;
    end else if (EX_BRANCH_TAKEN) begin
      // Redirect and squash the two younger instructions
      PC_EN        = 1'b1;
      IF_ID_EN     = 1'b1;
      ID_EX_EN     = 1'b1;
      EX_MEM_EN    = 1'b1;
      MEM_WB_EN    = 1'b1;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_FLUSH  = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in ID for one cycle and inject a bubble into EX
      ID_EX_EN     = 1'b1;
      ID_EX_FLUSH  = 1'b1;
      EX_MEM_EN    = 1'b1;
      MEM_WB_EN    = 1'b1;
    end else begin
      PC_EN        = 1'b1;
      IF_ID_EN     = 1'b1;
      ID_EX_EN     = 1'b1;
      EX_MEM_EN    = 1'b1;
      MEM_WB_EN    = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Next counter values; both wrap naturally at 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PC_EN) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (IF_ID_FLUSH || ID_EX_FLUSH || EX_MEM_FLUSH) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Reset cycles are not counted as stalls
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign STALL_COUNT = stall_cnt_q;
  assign FLUSH_COUNT = flush_cnt_q;
`else
  // Performance counters are not built in this configuration
`endif

endmodule
